// File: rtl/bsg_chip_link_traffic_node_if.sv
// Ready-and link bundle between a traffic node and its io/mem link.
// master is the traffic node side, slave is the link side.
interface bsg_chip_link_traffic_node_if #(parameter int width_p = 64);
  logic               in_v_i;
  logic [width_p-1:0] in_data_i;
  logic               in_ready_and_o;
  logic               out_v_o;
  logic [width_p-1:0] out_data_o;
  logic               out_ready_and_i;

  modport master (input  in_v_i, in_data_i, out_ready_and_i,
                  output in_ready_and_o, out_v_o, out_data_o);
  modport slave  (output in_v_i, in_data_i, out_ready_and_i,
                  input  in_ready_and_o, out_v_o, out_data_o);
endinterface

// File: rtl/bsg_chip_link_traffic_node.sv
// Core-clock link traffic endpoint: buffered loopback or incrementing
// pattern generate/check, with sent/received/error counters.
module bsg_chip_link_traffic_node
  #(parameter int width_p     = 64,
    parameter int els_p       = 2,
    parameter int cnt_width_p = 32)
  (input  logic                   clk_i,
   input  logic                   reset_i,
   input  logic                   start_i,
   input  logic                   stop_i,
   input  logic                   mode_i,
   input  logic [width_p-1:0]     seed_i,
   bsg_chip_link_traffic_node_if.master link_io,
   output logic                   busy_o,
   output logic                   error_o,
   output logic [cnt_width_p-1:0] sent_count_o,
   output logic [cnt_width_p-1:0] recv_count_o,
   output logic [cnt_width_p-1:0] err_count_o);

  localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int cw_lp    = ptr_w_lp + 1;
  localparam logic [cw_lp-1:0] full_cnt_lp = cw_lp'(els_p);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOOP  = 2'd1;
  localparam logic [1:0] GEN   = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  logic [1:0]             state_q, state_d;
  logic                   mode_q, mode_d;
  logic [width_p-1:0]     pattern_q, pattern_d, expect_q, expect_d;
  logic [cnt_width_p-1:0] sent_q, sent_d, recv_q, recv_d, errc_q, errc_d;
  logic                   error_q, error_d;
  logic [ptr_w_lp-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [cw_lp-1:0]       cnt_q, cnt_d;
  logic [width_p-1:0]     mem_q [els_p];

  logic               empty, full, in_rdy, out_v, send, recv, enq, deq, mism;
  logic [width_p-1:0] out_data;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == full_cnt_lp);

  // Full FIFO refuses input even when it is being dequeued the same cycle.
  always_comb begin
    in_rdy   = 1'b0;
    out_v    = 1'b0;
    out_data = pattern_q;
    case (state_q)
      LOOP: begin
        in_rdy   = ~full;
        out_v    = ~empty;
        out_data = mem_q[rptr_q];
      end
      GEN: begin
        in_rdy = 1'b1;
        out_v  = 1'b1;
      end
      DRAIN: begin
        if (mode_q) in_rdy = 1'b1;
        else begin
          out_v    = ~empty;
          out_data = mem_q[rptr_q];
        end
      end
      default: ;
    endcase
  end

  assign send = out_v & link_io.out_ready_and_i;
  assign recv = link_io.in_v_i & in_rdy;
  assign enq  = recv & ~mode_q;
  assign deq  = send & ~mode_q;
  assign mism = recv & mode_q & (link_io.in_data_i != expect_q);

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    pattern_d = pattern_q;
    expect_d  = expect_q;
    sent_d    = sent_q;
    recv_d    = recv_q;
    errc_d    = errc_q;
    error_d   = error_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    cnt_d     = cnt_q;
    if (state_q == IDLE) begin
      if (start_i) begin
        state_d   = mode_i ? GEN : LOOP;
        mode_d    = mode_i;
        pattern_d = seed_i;
        expect_d  = seed_i;
        sent_d    = '0;
        recv_d    = '0;
        errc_d    = '0;
        error_d   = 1'b0;
        wptr_d    = '0;
        rptr_d    = '0;
        cnt_d     = '0;
      end
    end else begin
      if (send) sent_d = sent_q + cnt_width_p'(1);
      if (recv) recv_d = recv_q + cnt_width_p'(1);
      if (send & mode_q) pattern_d = pattern_q + width_p'(1);
      // expect advances on every receive so one bad word does not desync the rest
      if (recv & mode_q) expect_d = expect_q + width_p'(1);
      if (mism) begin
        error_d = 1'b1;
        if (~&errc_q) errc_d = errc_q + cnt_width_p'(1);
      end
      if (enq) wptr_d = wptr_q + ptr_w_lp'(1);
      if (deq) rptr_d = rptr_q + ptr_w_lp'(1);
      cnt_d = cnt_q + cw_lp'(enq) - cw_lp'(deq);
      case (state_q)
        LOOP, GEN: if (stop_i) state_d = DRAIN;
        DRAIN:     if (mode_q ? (recv_q == sent_q) : empty) state_d = IDLE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      mode_q    <= 1'b0;
      pattern_q <= '0;
      expect_q  <= '0;
      sent_q    <= '0;
      recv_q    <= '0;
      errc_q    <= '0;
      error_q   <= 1'b0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      pattern_q <= pattern_d;
      expect_q  <= expect_d;
      sent_q    <= sent_d;
      recv_q    <= recv_d;
      errc_q    <= errc_d;
      error_q   <= error_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      cnt_q     <= cnt_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk_i) begin
    if (enq) mem_q[wptr_q] <= link_io.in_data_i;
  end

  assign link_io.in_ready_and_o = in_rdy;
  assign link_io.out_v_o        = out_v;
  assign link_io.out_data_o     = out_data;
  assign busy_o                 = (state_q != IDLE);
  assign error_o                = error_q;
  assign sent_count_o           = sent_q;
  assign recv_count_o           = recv_q;
  assign err_count_o            = errc_q;

endmodule

// File: tb/tb_bsg_chip_link_traffic_node.sv
// Randomized and directed bench for the link traffic node against a
// queue-based behavioural model checked every cycle.
module tb_bsg_chip_link_traffic_node;
  localparam int W = 64, ELS = 2, C = 32;

  typedef enum int {P_IDLE, P_LOOP, P_GEN, P_DRAIN} ph_t;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, stop = 1'b0, mode = 1'b0;
  logic [W-1:0] seed = '0;
  logic busy, err;
  logic [C-1:0] sent_c, recv_c, errc;

  bsg_chip_link_traffic_node_if #(.width_p(W)) lif();

  bsg_chip_link_traffic_node #(.width_p(W), .els_p(ELS), .cnt_width_p(C)) dut (
    .clk_i(clk), .reset_i(rst), .start_i(start), .stop_i(stop), .mode_i(mode),
    .seed_i(seed), .link_io(lif), .busy_o(busy), .error_o(err),
    .sent_count_o(sent_c), .recv_count_o(recv_c), .err_count_o(errc));

  always #5 clk = ~clk;

  int tests = 0, fails = 0;

  // environment: 0 manual input, 1 external loopback wire, 2 random inbound
  int src = 0;
  bit rnd = 0, rnd_rdy = 0, tog = 0;
  logic [W-1:0] ret_q[$], out_log[$];
  int ret_cnt = 0, corrupt_idx = -1, rdy_cnt = 0;

  // reference model
  ph_t m_ph;
  bit m_mode, m_err;
  logic [W-1:0] m_fifo[$];
  logic [W-1:0] m_pat, m_exp;
  logic [C-1:0] m_sent, m_recv, m_errc;

  logic [W-1:0] exp2 [4];

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  function automatic void m_reset();
    m_ph = P_IDLE; m_mode = 0; m_err = 0; m_fifo.delete();
    m_pat = '0; m_exp = '0; m_sent = '0; m_recv = '0; m_errc = '0;
  endfunction

  // compare, environment bookkeeping, then advance model to post-edge state
  always @(negedge clk) begin
    bit e_ir, e_ov, ihs, ohs, done;
    logic [W-1:0] e_od, d;
    if (rst) begin
      chk("rst_out_v", lif.out_v_o, 0);
      chk("rst_in_ready", lif.in_ready_and_o, 0);
      chk("rst_busy", busy, 0);
      chk("rst_error", err, 0);
      chk("rst_sent", sent_c, 0);
      chk("rst_recv", recv_c, 0);
      chk("rst_errc", errc, 0);
    end else begin
      e_ir = 0; e_ov = 0; e_od = m_pat;
      case (m_ph)
        P_LOOP:  begin e_ir = m_fifo.size() < ELS; e_ov = m_fifo.size() > 0;
                       e_od = e_ov ? m_fifo[0] : '0; end
        P_GEN:   begin e_ir = 1; e_ov = 1; end
        P_DRAIN: if (m_mode) e_ir = 1;
                 else begin e_ov = m_fifo.size() > 0; e_od = e_ov ? m_fifo[0] : '0; end
        default: ;
      endcase
      chk("in_ready", lif.in_ready_and_o, e_ir);
      chk("out_v", lif.out_v_o, e_ov);
      if (e_ov) chk("out_data", lif.out_data_o, e_od);
      chk("busy", busy, m_ph != P_IDLE);
      chk("error", err, m_err);
      chk("sent_count", sent_c, m_sent);
      chk("recv_count", recv_c, m_recv);
      chk("err_count", errc, m_errc);

      if (src == 1 && lif.in_v_i && lif.in_ready_and_o && ret_q.size() > 0) void'(ret_q.pop_front());
      if (lif.out_v_o && lif.out_ready_and_i) begin
        out_log.push_back(lif.out_data_o);
        rdy_cnt++;
        if (src == 1) begin
          d = lif.out_data_o;
          if (ret_cnt == corrupt_idx) d[0] = ~d[0];
          ret_q.push_back(d);
          ret_cnt++;
        end
      end

      ihs = lif.in_v_i && e_ir;
      ohs = e_ov && lif.out_ready_and_i;
      if (m_ph == P_IDLE) begin
        if (start) begin
          m_ph = mode ? P_GEN : P_LOOP; m_mode = mode;
          m_pat = seed; m_exp = seed; m_fifo.delete();
          m_sent = '0; m_recv = '0; m_errc = '0; m_err = 0;
        end
      end else begin
        done = m_mode ? (m_recv == m_sent) : (m_fifo.size() == 0);
        if (ohs) begin
          m_sent = m_sent + 1;
          if (m_mode) m_pat = m_pat + 1; else void'(m_fifo.pop_front());
        end
        if (ihs) begin
          m_recv = m_recv + 1;
          if (m_mode) begin
            if (lif.in_data_i != m_exp) begin
              m_err = 1;
              if (m_errc != '1) m_errc = m_errc + 1;
            end
            m_exp = m_exp + 1;
          end else m_fifo.push_back(lif.in_data_i);
        end
        if ((m_ph == P_LOOP || m_ph == P_GEN) && stop) m_ph = P_DRAIN;
        else if (m_ph == P_DRAIN && done) m_ph = P_IDLE;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
    start = 0; stop = 0;
    if (tog) lif.out_ready_and_i = ~lif.out_ready_and_i;
    else if (rnd_rdy) lif.out_ready_and_i = ($urandom % 3) != 0;
    if (src == 1) begin
      lif.in_v_i    = (ret_q.size() > 0) && (!rnd || ($urandom % 4) != 0);
      lif.in_data_i = (ret_q.size() > 0) ? ret_q[0] : '0;
    end else if (src == 2) begin
      lif.in_v_i    = $urandom % 2;
      lif.in_data_i = {$urandom, $urandom};
    end
  endtask

  task automatic send_in(input logic [W-1:0] dat);
    bit acc = 0;
    lif.in_v_i = 1; lif.in_data_i = dat;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk); acc = lif.in_ready_and_o;
      tick();
    end
    lif.in_v_i = 0;
    chk("send_in_accepted", acc, 1);
  endtask

  task automatic wait_idle(input string nm);
    for (int i = 0; i < 500 && busy; i++) tick();
    chk(nm, busy, 0);
  endtask

  task automatic setup(input int s, input bit t, input bit rr, input bit r);
    src = s; tog = t; rnd_rdy = rr; rnd = r;
    lif.in_v_i = 0; ret_q.delete(); out_log.delete();
    ret_cnt = 0; corrupt_idx = -1; rdy_cnt = 0;
  endtask

  task automatic hard_reset();
    rst = 1; m_reset(); ret_q.delete(); lif.in_v_i = 0;
    tick(); rst = 0;
  endtask

  initial begin
    lif.in_v_i = 0; lif.in_data_i = '0; lif.out_ready_and_i = 0;
    m_reset();
    exp2[0] = 64'hFFFF_FFFF_FFFF_FFFE; exp2[1] = 64'hFFFF_FFFF_FFFF_FFFF;
    exp2[2] = 64'h0; exp2[3] = 64'h1;
    tick(); tick(); rst = 0; tick();

    // 1: loopback fills a 2-deep FIFO, third word stalls, then drains in order
    setup(0, 0, 0, 0);
    lif.out_ready_and_i = 0; mode = 0; start = 1; tick();
    send_in(64'h11); send_in(64'h22);
    lif.in_v_i = 1; lif.in_data_i = 64'h33;
    chk("t1_full_not_ready", lif.in_ready_and_o, 0);
    tick(); tick();
    lif.out_ready_and_i = 1;
    send_in(64'h33);
    stop = 1; tick();
    wait_idle("t1_idle");
    chk("t1_nout", out_log.size(), 3);
    chk("t1_out0", out_log.size() > 0 ? out_log[0] : 'x, 64'h11);
    chk("t1_out1", out_log.size() > 1 ? out_log[1] : 'x, 64'h22);
    chk("t1_out2", out_log.size() > 2 ? out_log[2] : 'x, 64'h33);
    chk("t1_sent", sent_c, 3); chk("t1_recv", recv_c, 3); chk("t1_errc", errc, 0);

    // 2: generate with wrapping seed over an external loopback wire
    setup(1, 0, 0, 0);
    lif.out_ready_and_i = 1; mode = 1; seed = 64'hFFFF_FFFF_FFFF_FFFE; start = 1; tick();
    tick(); tick(); tick();
    stop = 1; tick();
    wait_idle("t2_idle");
    chk("t2_nout", out_log.size(), 4);
    for (int i = 0; i < 4; i++) chk("t2_out", i < out_log.size() ? out_log[i] : 'x, exp2[i]);
    chk("t2_sent", sent_c, 4); chk("t2_recv", recv_c, 4); chk("t2_error", err, 0);

    // 3: third returned word corrupted in bit 0
    setup(1, 0, 0, 0);
    corrupt_idx = 2;
    mode = 1; seed = {$urandom, $urandom}; start = 1; tick();
    repeat (5) tick();
    stop = 1; tick();
    wait_idle("t3_idle");
    chk("t3_error", err, 1); chk("t3_errc", errc, 1); chk("t3_recv", recv_c, 6);

    // 4: outbound ready toggling 1010
    setup(1, 1, 0, 0);
    lif.out_ready_and_i = 1; mode = 1; seed = 64'h100; start = 1; tick();
    repeat (10) tick();
    stop = 1; tick();
    wait_idle("t4_idle");
    tog = 0;
    chk("t4_sent_vs_ready", sent_c, rdy_cnt);
    chk("t4_errc", errc, 0);

    // 5: reset while the loopback FIFO holds a word
    setup(0, 0, 0, 0);
    lif.out_ready_and_i = 0; mode = 0; start = 1; tick();
    send_in(64'hAB);
    rst = 1; m_reset(); #1;
    chk("t5_out_v", lif.out_v_o, 0); chk("t5_busy", busy, 0); chk("t5_recv", recv_c, 0);
    tick(); rst = 0; tick();
    mode = 0; start = 1; tick();
    chk("t5_fresh_empty", lif.out_v_o, 0);
    chk("t5_fresh_ready", lif.in_ready_and_o, 1);
    stop = 1; tick();
    wait_idle("t5_idle");

    // 6: start while busy is ignored; start+stop in IDLE starts a run
    setup(1, 0, 0, 0);
    lif.out_ready_and_i = 1; mode = 1; seed = 64'h40; start = 1; tick();
    tick();
    mode = 0; seed = 64'h999; start = 1; tick();
    chk("t6_still_gen", lif.out_v_o, 1);
    stop = 1; tick();
    wait_idle("t6_idle1");
    chk("t6_sent", sent_c, 3);
    setup(0, 0, 0, 0);
    mode = 0; start = 1; stop = 1; tick();
    chk("t6_busy", busy, 1);
    chk("t6_loop_ready", lif.in_ready_and_o, 1);
    stop = 1; tick();
    wait_idle("t6_idle2");

    // random runs in both modes, with stray starts and occasional reset
    for (int r = 0; r < 30; r++) begin
      int len;
      bit m;
      m = $urandom % 2;
      setup(m ? 1 : 2, 0, 1, 1);
      if (m && ($urandom % 3 == 0)) corrupt_idx = $urandom % 8;
      mode = m; seed = {$urandom, $urandom}; start = 1; tick();
      len = 5 + $urandom % 40;
      for (int i = 0; i < len; i++) begin
        if ($urandom % 10 == 0) begin mode = $urandom % 2; start = 1; end
        tick();
      end
      if ($urandom % 8 == 0) hard_reset();
      else begin
        stop = 1; tick();
        wait_idle("rand_idle");
      end
    end

    setup(0, 0, 0, 0);
    tick(); tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
